// File: rtl/bnn_layer_seq_if.sv
// Valid/ready bundle interface for the time-multiplexed binary-weight dense layer.
// The slave side is the layer; the master side is the upstream/downstream buffer pair.
interface bnn_layer_seq_if #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned DATA_W      = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_INPUTS*DATA_W-1:0]      in_data;
  logic [NUM_NEURONS*NUM_INPUTS-1:0] weights;
  logic [NUM_NEURONS*DATA_W-1:0]     bias;
  logic [1:0]                        act_mode;
  logic [NUM_NEURONS-1:0]            neuron_en;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_NEURONS*DATA_W-1:0]     out_data;

  modport slave (
    input  in_valid, in_data, weights, bias, act_mode, neuron_en, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, weights, bias, act_mode, neuron_en, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bnn_layer_seq.sv
// Binary-weight dense layer: NUM_PE neurons accumulate in parallel, one input per cycle,
// followed by saturation, selectable activation and per-neuron masking.
module bnn_layer_seq #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NUM_PE      = 4,
  parameter int unsigned DATA_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bnn_layer_seq_if.slave bus
);

  localparam int unsigned ACC_W = DATA_W + $clog2(NUM_INPUTS + 1) + 1;
  localparam int unsigned G     = NUM_NEURONS / NUM_PE;
  localparam int unsigned J_W   = $clog2(NUM_INPUTS);
  localparam int unsigned G_W   = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned N_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic [J_W-1:0] J_LAST = J_W'(NUM_INPUTS - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(G - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;

  logic [J_W-1:0] j_q;
  logic [G_W-1:0] g_q;
  logic           accept_c;
  logic           last_j_c;
  logic           last_c;

  logic [DATA_W-1:0]     x_q [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] w_q [NUM_NEURONS];
  logic [DATA_W-1:0]     b_q [NUM_NEURONS];
  logic [1:0]            mode_q;
  logic [NUM_NEURONS-1:0] en_q;

  logic signed [ACC_W-1:0] acc_q  [NUM_PE];
  logic signed [ACC_W-1:0] base_c [NUM_PE];
  logic signed [ACC_W-1:0] sum_c  [NUM_PE];
  logic [DATA_W-1:0]       y_c    [NUM_PE];
  logic [N_W-1:0]          n_c    [NUM_PE];
  logic signed [ACC_W-1:0] x_ext_c;

  logic [DATA_W-1:0]             out_q [NUM_NEURONS];
  logic [NUM_NEURONS*DATA_W-1:0] out_flat_c;

  // Negation happens at ACC_W, so the most negative input negates exactly.
  function automatic logic signed [ACC_W-1:0] pe_sum(
    input logic signed [ACC_W-1:0] base,
    input logic signed [ACC_W-1:0] xv,
    input logic                    w
  );
    return w ? (base + xv) : (base - xv);
  endfunction

  function automatic logic [DATA_W-1:0] post_proc(
    input logic signed [ACC_W-1:0] s,
    input logic [1:0]              mode,
    input logic                    en
  );
    logic [DATA_W-1:0] sat;
    logic [DATA_W-1:0] act;
    if (s > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                  sat = s[DATA_W-1:0];
    case (mode)
      2'd1:    act = sat[DATA_W-1] ? '0 : sat;
      2'd2:    act = sat[DATA_W-1] ? '1 : DATA_W'(1);
      default: act = sat;
    endcase
    return en ? act : '0;
  endfunction

  assign accept_c = (state_q == IDLE) && bus.in_valid;
  assign last_j_c = (j_q == J_LAST);
  assign last_c   = last_j_c && (g_q == G_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = ACCUM;
      ACCUM:   if (last_c)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_comb begin
    x_ext_c = {{(ACC_W-DATA_W){x_q[j_q][DATA_W-1]}}, x_q[j_q]};
    for (int p = 0; p < NUM_PE; p++) begin
      n_c[p]    = N_W'(int'(g_q) * int'(NUM_PE) + p);
      base_c[p] = (j_q == '0) ? {{(ACC_W-DATA_W){b_q[n_c[p]][DATA_W-1]}}, b_q[n_c[p]]}
                              : acc_q[p];
      sum_c[p]  = pe_sum(base_c[p], x_ext_c, w_q[n_c[p]][j_q]);
      y_c[p]    = post_proc(sum_c[p], mode_q, en_q[n_c[p]]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q    <= '0;
      g_q    <= '0;
      mode_q <= '0;
      en_q   <= '0;
      for (int i = 0; i < NUM_INPUTS; i++)  x_q[i] <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        w_q[n]   <= '0;
        b_q[n]   <= '0;
        out_q[n] <= '0;
      end
      for (int p = 0; p < NUM_PE; p++) acc_q[p] <= '0;
    end else begin
      if (accept_c) begin
        mode_q <= bus.act_mode;
        en_q   <= bus.neuron_en;
        for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= bus.in_data[i*DATA_W +: DATA_W];
        for (int n = 0; n < NUM_NEURONS; n++) begin
          w_q[n] <= bus.weights[n*NUM_INPUTS +: NUM_INPUTS];
          b_q[n] <= bus.bias[n*DATA_W +: DATA_W];
        end
      end
      if (state_q == ACCUM) begin
        for (int p = 0; p < NUM_PE; p++) acc_q[p] <= sum_c[p];
        // Group finished: commit its neurons and wrap straight into the next group.
        if (last_j_c) begin
          for (int p = 0; p < NUM_PE; p++) out_q[n_c[p]] <= y_c[p];
          j_q <= '0;
          g_q <= (g_q == G_LAST) ? '0 : g_q + G_W'(1);
        end else begin
          j_q <= j_q + J_W'(1);
        end
      end
    end
  end

  always_comb begin
    out_flat_c = '0;
    for (int n = 0; n < NUM_NEURONS; n++) out_flat_c[n*DATA_W +: DATA_W] = out_q[n];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_flat_c;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Scoreboard bench for bnn_layer_seq: directed and random bundles against an arithmetic
// reference model, plus backpressure, mid-run reset and NUM_PE corner instances.
module tb_bnn_layer_seq;

  localparam int unsigned NI  = 16;
  localparam int unsigned NN  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned PE  = 4;
  localparam int          LAT = int'((NN / PE) * NI);
  localparam int unsigned VW  = NN * DW;
  localparam int unsigned XW  = NI * DW;
  localparam int unsigned WW  = NN * NI;

  typedef logic [VW-1:0] vec_t;
  typedef logic [XW-1:0] xvec_t;
  typedef logic [WW-1:0] wvec_t;
  typedef struct {
    vec_t data;
    int   acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rand_bp = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_layer_seq_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(DW)) mbus ();
  bnn_layer_seq_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(DW)) c1bus ();
  bnn_layer_seq_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(DW)) c16bus ();

  bnn_layer_seq #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .NUM_PE(PE), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(mbus));
  bnn_layer_seq #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .NUM_PE(1), .DATA_W(DW)) dut_pe1 (
    .clk(clk), .rst_n(rst_n), .bus(c1bus));
  bnn_layer_seq #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .NUM_PE(NN), .DATA_W(DW)) dut_pe16 (
    .clk(clk), .rst_n(rst_n), .bus(c16bus));

  // Reference: signed dot product with +/-1 weights, clamp, activation, mask.
  function automatic vec_t model(input xvec_t x, input wvec_t w, input vec_t b,
                                 input logic [1:0] m, input logic [NN-1:0] en);
    vec_t   r;
    longint s, v;
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    r  = '0;
    for (int n = 0; n < int'(NN); n++) begin
      s = longint'($signed(b[n*DW +: DW]));
      for (int j = 0; j < int'(NI); j++) begin
        v = longint'($signed(x[j*DW +: DW]));
        s = w[n*NI + j] ? s + v : s - v;
      end
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (m == 2'd1 && s < 0) s = 0;
      if (m == 2'd2) s = (s < 0) ? -1 : 1;
      if (!en[n]) s = 0;
      r[n*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  function automatic vec_t rep(input logic [DW-1:0] v);
    vec_t r;
    for (int n = 0; n < int'(NN); n++) r[n*DW +: DW] = v;
    return r;
  endfunction

  function automatic xvec_t xrep(input logic [DW-1:0] v);
    xvec_t r;
    for (int j = 0; j < int'(NI); j++) r[j*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [1023:0] rnd_wide();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input vec_t got, input vec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Drive one bundle, hold until accepted, log expectation, then scramble the inputs.
  task automatic send(input xvec_t x, input wvec_t w, input vec_t b, input logic [1:0] m,
                      input logic [NN-1:0] en, input vec_t exp_v);
    int n;
    @(posedge clk); #1;
    mbus.in_data   = x;
    mbus.weights   = w;
    mbus.bias      = b;
    mbus.act_mode  = m;
    mbus.neuron_en = en;
    mbus.in_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (mbus.in_ready || n > 2000) break;
      n++;
    end
    if (!mbus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1 after %0d cycles", n);
      mbus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    mbus.in_valid = 1'b0;
    sb.push_back('{exp_v, cyc});
    mbus.in_data   = XW'(rnd_wide());
    mbus.weights   = WW'(rnd_wide());
    mbus.bias      = VW'(rnd_wide());
    mbus.act_mode  = 2'($urandom_range(0, 3));
    mbus.neuron_en = NN'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_bp) mbus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency at rise, busy/hold flags, data compared on each handshake.
  logic prev_valid = 1'b0;
  logic ready_bad = 1'b0;
  logic hold_bad = 1'b0;
  vec_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      ready_bad  = 1'b0;
      hold_bad   = 1'b0;
    end else begin
      if (mbus.out_valid) begin
        if (mbus.in_ready) ready_bad = 1'b1;
        if (!prev_valid) begin
          held = mbus.out_data;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid got 1 want 0 at cycle %0d", cyc);
          end else if (cyc - sb[0].acc_cyc != LAT) begin
            errors++;
            $display("FAIL latency got %0d want %0d", cyc - sb[0].acc_cyc, LAT);
          end
        end else if (mbus.out_data !== held) begin
          hold_bad = 1'b1;
        end
        if (mbus.out_ready && sb.size() > 0) begin
          checks++;
          if (mbus.out_data !== sb[0].data) begin
            errors++;
            $display("FAIL out_data got %h want %h", mbus.out_data, sb[0].data);
          end
          checks++;
          if (ready_bad || hold_bad) begin
            errors++;
            $display("FAIL busy_flags got in_ready_seen=%0b data_moved=%0b want 0 0",
                     ready_bad, hold_bad);
          end
          void'(sb.pop_front());
          ready_bad = 1'b0;
          hold_bad  = 1'b0;
        end
      end else if (sb.size() > 0 && mbus.in_ready) begin
        ready_bad = 1'b1;
      end
      prev_valid = mbus.out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    xvec_t x;
    wvec_t w;
    vec_t  b, e;
    logic [1:0] m;
    logic [NN-1:0] en;
    int n, rel_cyc, c0, ra, rb;
    vec_t da, db;

    mbus.in_valid = 1'b0; mbus.in_data = '0; mbus.weights = '0; mbus.bias = '0;
    mbus.act_mode = '0; mbus.neuron_en = '0; mbus.out_ready = 1'b1;
    c1bus.in_valid = 1'b0; c1bus.in_data = '0; c1bus.weights = '0; c1bus.bias = '0;
    c1bus.act_mode = '0; c1bus.neuron_en = '0; c1bus.out_ready = 1'b1;
    c16bus.in_valid = 1'b0; c16bus.in_data = '0; c16bus.weights = '0; c16bus.bias = '0;
    c16bus.act_mode = '0; c16bus.neuron_en = '0; c16bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", vec_t'(mbus.in_ready), vec_t'(1));
    chk("rst_out_valid", vec_t'(mbus.out_valid), vec_t'(0));
    chk("rst_out_data", mbus.out_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: identity, negation/activations, saturation.
    send(xrep(16'h0001), '1, '0, 2'd0, '1, rep(16'h0010));
    send(xrep(16'h0001), '0, '0, 2'd0, '1, rep(16'hFFF0));
    send(xrep(16'h0001), '0, '0, 2'd1, '1, rep(16'h0000));
    send(xrep(16'h0001), '0, '0, 2'd2, '1, rep(16'hFFFF));
    send(xrep(16'h0001), '0, rep(16'h0020), 2'd2, '1, rep(16'h0001));
    send(xrep(16'h7FFF), '1, rep(16'h7FFF), 2'd0, '1, rep(16'h7FFF));
    send(xrep(16'h8000), '1, '0, 2'd0, '1, rep(16'h8000));
    send(xrep(16'h8000), '0, '0, 2'd0, '1, rep(16'h7FFF));

    // Mixed weights with neuron 3 masked off.
    for (int j = 0; j < int'(NI); j++) x[j*DW +: DW] = DW'(j);
    for (int k = 0; k < int'(NN); k++) begin
      b[k*DW +: DW] = DW'(k);
      for (int j = 0; j < int'(NI); j++) w[k*NI + j] = 1'((k + j) % 2);
    end
    en = '1;
    en[3] = 1'b0;
    send(x, w, b, 2'd0, en, model(x, w, b, 2'd0, en));
    wait_drain();

    // Backpressure: stall DONE for 10 cycles while the next bundle is already offered.
    @(posedge clk); #1 mbus.out_ready = 1'b0;
    rel_cyc = 0;
    fork
      begin
        for (int t = 0; t < 2; t++) begin
          x = XW'(rnd_wide()); w = WW'(rnd_wide()); b = VW'(rnd_wide());
          m = 2'($urandom_range(0, 3)); en = NN'($urandom);
          send(x, w, b, m, en, model(x, w, b, m, en));
        end
      end
      begin
        n = 0;
        while (!mbus.out_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        repeat (10) @(negedge clk);
        chk("stall_out_valid", vec_t'(mbus.out_valid), vec_t'(1));
        chk("stall_in_ready", vec_t'(mbus.in_ready), vec_t'(0));
        @(posedge clk); #1;
        rel_cyc = cyc;
        mbus.out_ready = 1'b1;
      end
    join
    if (sb.size() > 0) chk("accept_after_done", vec_t'(sb[0].acc_cyc - rel_cyc), vec_t'(2));
    else chk("accept_after_done_pending", vec_t'(sb.size()), vec_t'(1));
    wait_drain();

    // Random bundles under random backpressure.
    rand_bp = 1'b1;
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < int'(NI); j++)
        x[j*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom)
                                                     : DW'(int'($urandom_range(0, 64)) - 32);
      w = WW'(rnd_wide()); b = VW'(rnd_wide());
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < int'(NN); k++) b[k*DW +: DW] = DW'(int'($urandom_range(0, 200)) - 100);
      m = 2'($urandom_range(0, 3)); en = NN'($urandom);
      send(x, w, b, m, en, model(x, w, b, m, en));
    end
    wait_drain();
    rand_bp = 1'b0;
    @(posedge clk); #1 mbus.out_ready = 1'b1;

    // Reset partway through ACCUM, then a clean transaction.
    send(xrep(16'h0001), '1, '0, 2'd0, '1, rep(16'h0010));
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", vec_t'(mbus.out_valid), vec_t'(0));
    chk("midrst_out_data", mbus.out_data, '0);
    chk("midrst_in_ready", vec_t'(mbus.in_ready), vec_t'(1));
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (70) @(negedge clk);
    send(xrep(16'h0001), '1, '0, 2'd0, '1, rep(16'h0010));
    wait_drain();

    // NUM_PE corners: identity sum on the single-PE and all-PE instances.
    @(posedge clk); #1;
    c1bus.in_data = xrep(16'h0001); c1bus.weights = '1; c1bus.bias = '0;
    c1bus.act_mode = 2'd0; c1bus.neuron_en = '1; c1bus.in_valid = 1'b1;
    c16bus.in_data = xrep(16'h0001); c16bus.weights = '1; c16bus.bias = '0;
    c16bus.act_mode = 2'd0; c16bus.neuron_en = '1; c16bus.in_valid = 1'b1;
    @(negedge clk);
    chk("pe1_in_ready", vec_t'(c1bus.in_ready), vec_t'(1));
    chk("pe16_in_ready", vec_t'(c16bus.in_ready), vec_t'(1));
    @(posedge clk); #1;
    c0 = cyc;
    c1bus.in_valid = 1'b0;
    c16bus.in_valid = 1'b0;
    ra = -1; rb = -1; da = '0; db = '0;
    n = 0;
    while ((ra < 0 || rb < 0) && n < 400) begin
      @(negedge clk);
      n++;
      if (c1bus.out_valid && ra < 0) begin ra = cyc - c0; da = c1bus.out_data; end
      if (c16bus.out_valid && rb < 0) begin rb = cyc - c0; db = c16bus.out_data; end
    end
    chk("pe1_latency", vec_t'(ra), vec_t'(256));
    chk("pe16_latency", vec_t'(rb), vec_t'(16));
    chk("pe1_data", da, rep(16'h0010));
    chk("pe16_data", db, rep(16'h0010));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
